axis_nb_to_axis_fifo: RTL and testbench
=======================================

Name: axis_nb_to_axis_fifo

Overview:
- Receiving end of the non-blocking stream (`axis_nb_if`). The upstream producer cannot be stalled.
- The block buffers beats in a FIFO and re-emits them as a backpressured ready/valid stream (`axis_if` master) toward consumers.
- It sits between free-running sources (link receivers, sensors) and handshaked pipelines.
- It reports fill level and counts beats dropped on overflow.

Parameters:
- `data_t`, `logic [7:0]`, beat payload type; must match both interface instances.
- `DEPTH`, 8, number of FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16, width of the dropped-beat counter.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in`  `axis_nb_if.slave`  `$bits(data_t)`+1  non-blocking input (`valid`, `data`); no ready.
- `out`  `axis_if.master`  `$bits(data_t)`+2  backpressured output (`valid`, `data`; `ready` input).
- `level`  output  `$clog2(DEPTH+1)`  current number of stored beats.
- `overflow`  output  1  sticky flag: at least one beat was dropped since the last clear.
- `drop_count`  output  `CNT_W`  saturating count of dropped beats.
- `clear_stats`  input  1  synchronous clear of `overflow` and `drop_count`.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - `level`=0, `out.valid`=0, `overflow`=0, `drop_count`=0.
  - Read and write pointers go to 0.
  - Storage contents are don't-care.
  - `out.valid` must be 0 in every cycle where `rst` is high.
  - A reset mid-stream discards all buffered beats; no partial beat survives.
- Pointers:
  - Read and write pointers are `$clog2(DEPTH)`+1 bits wide. The extra MSB disambiguates full from empty.
  - Pointers wrap naturally modulo 2·`DEPTH`.
- Status:
  - `empty` = pointers equal.
  - `full` = indices equal and MSBs differ.
  - `level` = `wr_ptr` − `rd_ptr`, as unsigned modulo arithmetic.
- Output:
  - `out.valid` = !`empty`.
  - `out.data` = `mem[rd_idx]`, read combinationally from the flop array.
  - Latency: a beat written at edge N is visible on `out` in the cycle after edge N (1-cycle latency when empty).
- Pop: when `out.valid && out.ready` at an edge, `rd_ptr` increments.
- Push: when `in.valid` at an edge and (!`full` || pop this cycle), `mem[wr_idx]` ← `in.data` and `wr_ptr` increments.
  - Full with simultaneous pop: the push is accepted and `level` stays at `DEPTH`.
- Drop: `in.valid && full && !pop` → the beat is discarded.
  - Storage and pointers are unchanged.
  - `overflow` ← 1.
  - `drop_count` increments, saturating at 2^`CNT_W`−1 (no wrap).
- Empty with push: `out.valid` is 0 in the same cycle; there is no combinational bypass from `in` to `out`.
- Statistics clear: `clear_stats`=1 clears `overflow` and `drop_count` to 0 at the edge.
  - If a drop occurs in the same cycle, the clear wins for the count's base and the drop is still counted: result `overflow`=1, `drop_count`=1.
- Protocol guarantees on `out` (formally checked with the master-port property set):
  - Once `out.valid` is 1 with `out.ready`=0, `out.valid` stays 1 and `out.data` stays stable until accepted.
  - `out.valid` only falls after a cycle with `out.ready`=1.
- `out.ready` is sampled only; it never combinationally affects `out.valid` or `out.data`.

Decomposition:
- Shared package `axis_pkg`: `clog2`-based helper function for pointer/level widths and the saturating-increment function. No new data typedefs; `data_t` stays a type parameter.
- One natural sub-module, `axis_fifo_mem`: `DEPTH` × `data_t` flop array with one synchronous write port and one combinational read port.
  - Pointer, status and statistics logic stay in the top module.
- The top module instantiates the existing master-port property checker on `out` under formal/sim-only compilation.

Test Plan (`DEPTH`=4, `data_t`=`logic [7:0]`):
- Reset: hold `rst` 3 cycles with `in.valid`=1, data 0xAA → `out.valid`=0 and `level`=0 throughout; after release, no 0xAA appears.
- Latency: push 0x11 at edge N with `out.ready`=1 → `out.valid`=1 with data 0x11 in the cycle after N; popped at N+1; `level` back to 0.
- Fill and stall: push 0x01..0x04 with `out.ready`=0 → `level`=4 and `out.data` stable at 0x01; then push 0x05 → dropped, `overflow`=1, `drop_count`=1. Raise `ready` → pops 0x01..0x04 in order, no 0x05.
- Full with simultaneous pop: FIFO full with 0x01..0x04, push 0x05 while `out.ready`=1 → 0x01 popped, 0x05 stored, `level` stays 4, `drop_count` unchanged; drain order 0x02, 0x03, 0x04, 0x05.
- Wrap-around: stream 20 beats 0x00..0x13 with `ready` toggling 1/0 every cycle and `in.valid` every other cycle → all 20 out in order, zero drops, pointers wrap ≥ 2 times.
- Statistics: `CNT_W`=2, force 5 drops → `drop_count` saturates at 3. `clear_stats` coincident with a drop → `overflow`=1, `drop_count`=1; a `clear_stats` with no drop → both 0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-stream style blocks: pointer/level width
// derivation and a saturating increment for statistics counters.
package axis_pkg;

  // Index width for a power-of-two DEPTH (one bit per address line).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer width: index plus one wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return idx_w(depth) + 1;
  endfunction

  // Width needed to hold any occupancy from 0 up to and including DEPTH.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Backpressured ready/valid stream; a beat moves when valid and ready are
// both high at a rising clock edge.
interface axis_if #(
  parameter type data_t = logic [7:0]
) ();
  logic  valid;
  logic  ready;
  data_t data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/axis_nb_if.sv
// Non-blocking stream: the producer asserts valid whenever it has a beat and
// cannot be held off, so there is no ready.
interface axis_nb_if #(
  parameter type data_t = logic [7:0]
) ();
  logic  valid;
  data_t data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/axis_fifo_mem.sv
// DEPTH x data_t flop array: one synchronous write port, one combinational
// read port.
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [idx_w(DEPTH)-1:0] waddr,
  input  data_t                   wdata,
  input  logic [idx_w(DEPTH)-1:0] raddr,
  output data_t                   rdata
);

  data_t mem [DEPTH];

  // Store the incoming beat at the write index.
  // NOTE: storage has no reset; the pointers alone decide which entries are
  // meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_if_master_checker.sv
// Simulation/formal-only protocol checker for the master side of axis_if:
// valid is low in reset, and a stalled beat keeps valid and data stable.
module axis_if_master_checker #(
  parameter type data_t = logic [7:0]
) (
  input logic  clk,
  input logic  rst,
  input logic  valid,
  input logic  ready,
  input data_t data
);

  logic  prev_valid;
  logic  prev_ready;
  logic  prev_rst;
  data_t prev_data;

  // Remember the previous cycle's handshake state for the stability check.
  always_ff @(posedge clk) begin
    prev_valid <= valid;
    prev_ready <= ready;
    prev_rst   <= rst;
    prev_data  <= data;
  end

  // A beat offered without ready must still be offered, unchanged, next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!valid);
    end else if (!prev_rst && prev_valid && !prev_ready) begin
      assert (valid);
      assert (data == prev_data);
    end
  end

endmodule

// File: rtl/axis_nb_to_axis_fifo.sv
// Bridges a non-blocking producer onto a backpressured stream through a
// DEPTH-entry FIFO. Beats arriving while full (and not draining) are dropped
// and counted.
module axis_nb_to_axis_fifo
  import axis_pkg::*;
#(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 8,
  parameter int  CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  axis_nb_if.slave                  in,
  axis_if.master                    out,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      clear_stats
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  data_t            rd_data;

  // Occupancy status and the per-cycle transfer decisions.
  // NOTE: every signal gets a value on every path through this block so no
  // latch can be inferred.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
            (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    pop   = !rst && !empty && out.ready;
    push  = !rst && in.valid && (!full || pop);
    drop  = !rst && in.valid && full && !pop;
  end

  // Gated by rst so valid is low for the whole reset cycle, even before the
  // pointers have been cleared at its edge.
  assign out.valid = !empty && !rst;
  assign out.data  = rd_data;
  assign level     = LVL_W'(wr_ptr - rd_ptr);

  // Advance the pointers on accepted pushes and pops.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Drop statistics; a clear restarts the count but still records a
  // coincident drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
    end
  end

  axis_fifo_mem #(
    .data_t (data_t),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (in.data),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (rd_data)
  );

`ifndef SYNTHESIS
  axis_if_master_checker #(
    .data_t (data_t)
  ) u_out_chk (
    .clk   (clk),
    .rst   (rst),
    .valid (out.valid),
    .ready (out.ready),
    .data  (out.data)
  );
`endif

endmodule

// File: tb/tb_axis_nb_to_axis_fifo.sv
// Bench for axis_nb_to_axis_fifo (DEPTH=4, CNT_W=2): directed scenarios then
// random traffic, all compared against a queue-based model of the FIFO.
module tb_axis_nb_to_axis_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_stats;
  logic [2:0] level;
  logic       overflow;
  logic [1:0] drop_count;

  axis_nb_if #(.data_t(logic [7:0])) in_if ();
  axis_if    #(.data_t(logic [7:0])) out_if ();

  axis_nb_to_axis_fifo #(
    .data_t (logic [7:0]),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in_if),
    .out         (out_if),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int         m_drops;
  bit         m_ovf;
  bit         m_known = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs, update the
  // model with what the rising edge should do, then advance.
  task automatic step(input bit r, input bit iv, input logic [7:0] d,
                      input bit rdy, input bit clr);
    bit pop;
    bit drp;
    rst          = r;
    in_if.valid  = iv;
    in_if.data   = d;
    out_if.ready = rdy;
    clear_stats  = clr;
    #1;
    check("out_valid", out_if.valid, (!r && q.size() > 0));
    if (!r && q.size() > 0) check("out_data", out_if.data, q[0]);
    if (m_known) begin
      check("level", level, q.size());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
    end
    if (r) begin
      q.delete();
      m_ovf   = 0;
      m_drops = 0;
      m_known = 1;
    end else begin
      pop = (q.size() > 0) && rdy;
      drp = iv && (q.size() == DEPTH) && !pop;
      if (pop) popped.push_back(q.pop_front());
      if (iv && !drp) q.push_back(d);
      if (clr) begin
        m_ovf   = drp;
        m_drops = drp ? 1 : 0;
      end else if (drp) begin
        m_ovf = 1;
        if (m_drops < MAXC) m_drops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    clear_stats  = 1'b0;
    @(negedge clk);

    // Reset held with a live producer: nothing may be stored or shown.
    for (int i = 0; i < 3; i++) step(1, 1, 8'hAA, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 1, 0);
    check("no_aa_after_reset", popped.size(), 0);

    // Single beat latency through an empty FIFO.
    step(0, 1, 8'h11, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    check("latency_pop", popped.size() == 1 && popped[0] == 8'h11, 1);

    // Fill, stall, overflow, then drain in order.
    popped.delete();
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
    check("fill_level", level, 4);
    check("fill_head", out_if.data, 8'h01);
    step(0, 1, 8'h05, 0, 0);
    check("drop_ovf", overflow, 1);
    check("drop_cnt", drop_count, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    check("drain_n", popped.size(), 4);
    for (int i = 0; i < 4; i++) check("drain_order", popped[i], 8'(i + 1));

    // Full with a simultaneous pop: the push is accepted.
    popped.delete();
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'h05, 1, 0);
    check("fullpop_level", level, 4);
    check("fullpop_cnt", drop_count, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    check("fullpop_n", popped.size(), 5);
    for (int i = 0; i < 5; i++) check("fullpop_order", popped[i], 8'(i + 1));

    // Wrap-around: 20 beats, input every other cycle, ready toggling.
    popped.delete();
    for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, 8'(i / 2), (i % 2) == 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
    check("wrap_n", popped.size(), 20);
    for (int i = 0; i < 20; i++) check("wrap_order", popped[i], 8'(i));
    check("wrap_no_drop", drop_count, 1);

    // Statistics: saturation, clear coincident with a drop, plain clear.
    step(0, 0, 8'h00, 0, 1);
    check("clr_cnt", drop_count, 0);
    check("clr_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h30 + 8'(i), 0, 0);
    check("sat_cnt", drop_count, 3);
    step(0, 1, 8'h40, 0, 1);
    check("clrdrop_ovf", overflow, 1);
    check("clrdrop_cnt", drop_count, 1);
    step(0, 0, 8'h00, 0, 1);
    check("clr2_ovf", overflow, 0);
    check("clr2_cnt", drop_count, 0);

    // Reset mid-stream discards the buffered beats.
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check("midrst_level", level, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
